// File: rtl/memShare_config_pkg.sv
// rtl/memShare_config_pkg.sv - design-rule flag indices shared with the memShare monitor
package memShare_config_pkg;
    localparam int MEMSHARE_DRC_NUM = 3;
    localparam int MEMSHARE_DRC1    = 0;
    localparam int MEMSHARE_DRC2    = 1;
    localparam int MEMSHARE_DRC3    = 2;
endpackage

// File: rtl/memshare_alloc_sched.sv
// rtl/memshare_alloc_sched.sv - buffers lane request masks and emits one or two allocation sequences
module memshare_alloc_sched
    import memShare_config_pkg::*;
#(
    parameter int RQST_W     = 8,
    parameter int SEQ_CAP    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PCYC_CNT_W = 8
) (
    input  logic                        sys_clk,
    input  logic                        rstn,
    input  logic                        in_valid_i,
    input  logic [RQST_W-1:0]           in_mask_i,
    output logic                        in_ready_o,
    output logic                        isGtr_o,
    input  logic [MEMSHARE_DRC_NUM-1:0] is_drc_i,
    input  logic                        pipeCycle_begin_i,
    output logic                        alloc_valid_o,
    output logic [RQST_W-1:0]           alloc_mask_o,
    output logic                        alloc_seq_o,
    output logic                        alloc_last_o,
    output logic                        ovf_err_o,
    output logic [PCYC_CNT_W-1:0]       pipe_cycle_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT_GEN, SEQ2, BUBBLE} state_t;

    state_t                state_q, state_d;
    logic [RQST_W-1:0]     cur_q, cur_d;
    logic                  drc2_q, drc2_d;
    logic                  ovf_q, ovf_d;
    logic [PCYC_CNT_W-1:0] pcyc_q, pcyc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [RQST_W-1:0]     mem_q [FIFO_DEPTH];

    logic              push, pop, non_empty, full, is_gtr;
    logic [RQST_W-1:0] seq1_mask, seq2_mask;
    int                pc;
    logic              unused_drc;

    assign unused_drc = is_drc_i[MEMSHARE_DRC1] ^ is_drc_i[MEMSHARE_DRC3];
    assign non_empty  = (count_q != '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_ready_o = ~full;
    assign push       = in_valid_i & ~full;

    // Walk set bits low to high: first SEQ_CAP go to sequence 1, next SEQ_CAP to sequence 2, rest dropped.
    always_comb begin
        seq1_mask = '0;
        seq2_mask = '0;
        pc        = 0;
        for (int i = 0; i < RQST_W; i++) begin
            if (cur_q[i]) begin
                if (pc < SEQ_CAP) begin
                    seq1_mask[i] = 1'b1;
                end else if (pc < 2 * SEQ_CAP) begin
                    seq2_mask[i] = 1'b1;
                end
                pc = pc + 1;
            end
        end
        is_gtr = (pc > SEQ_CAP);
    end

    always_comb begin
        alloc_valid_o = 1'b0;
        alloc_mask_o  = '0;
        alloc_seq_o   = 1'b0;
        alloc_last_o  = 1'b0;
        isGtr_o       = 1'b0;
        case (state_q)
            SHIFT_GEN: begin
                alloc_valid_o = 1'b1;
                alloc_mask_o  = seq1_mask;
                isGtr_o       = is_gtr;
                alloc_last_o  = ~is_gtr;
            end
            SEQ2: begin
                alloc_valid_o = 1'b1;
                alloc_mask_o  = seq2_mask;
                alloc_seq_o   = 1'b1;
                alloc_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (non_empty) begin
                    state_d = SHIFT_GEN;
                    pop     = 1'b1;
                end
            end
            SHIFT_GEN: begin
                if (is_gtr) begin
                    state_d = SEQ2;
                end else if (is_drc_i[MEMSHARE_DRC2]) begin
                    state_d = BUBBLE;
                end else if (non_empty) begin
                    state_d = SHIFT_GEN;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEQ2: begin
                if (drc2_q) begin
                    state_d = BUBBLE;
                end else if (non_empty) begin
                    state_d = SHIFT_GEN;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (non_empty) begin
                    state_d = SHIFT_GEN;
                    pop     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cur_d    = pop ? mem_q[rd_ptr_q] : cur_q;
        drc2_d   = (state_q == SHIFT_GEN) ? is_drc_i[MEMSHARE_DRC2] : drc2_q;
        ovf_d    = ovf_q | ((state_q == SHIFT_GEN) && (pc > 2 * SEQ_CAP));
        pcyc_d   = pcyc_q + PCYC_CNT_W'(pipeCycle_begin_i);
    end

    assign ovf_err_o        = ovf_q;
    assign pipe_cycle_cnt_o = pcyc_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            drc2_q   <= 1'b0;
            ovf_q    <= 1'b0;
            pcyc_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            drc2_q   <= drc2_d;
            ovf_q    <= ovf_d;
            pcyc_q   <= pcyc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage carries no reset; occupancy tracking alone decides validity.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_mask_i;
        end
    end
endmodule

// File: tb/tb_memshare_alloc_sched.sv
// tb/tb_memshare_alloc_sched.sv - randomized bench for memshare_alloc_sched against a request-level model
module tb_memshare_alloc_sched;
    import memShare_config_pkg::*;

    logic                        sys_clk = 1'b0;
    logic                        rstn;
    logic                        in_valid;
    logic [7:0]                  in_mask;
    logic [MEMSHARE_DRC_NUM-1:0] is_drc;
    logic                        pipe;

    logic       rdy [2];
    logic       gtr [2];
    logic       av  [2];
    logic [7:0] am  [2];
    logic       aseq[2];
    logic       alast[2];
    logic       ovf [2];
    logic [7:0] cnt [2];

    int vectors = 0;
    int errs    = 0;

    always #5 sys_clk = ~sys_clk;

    memshare_alloc_sched u_dut (
        .sys_clk(sys_clk), .rstn(rstn), .in_valid_i(in_valid), .in_mask_i(in_mask),
        .in_ready_o(rdy[0]), .isGtr_o(gtr[0]), .is_drc_i(is_drc), .pipeCycle_begin_i(pipe),
        .alloc_valid_o(av[0]), .alloc_mask_o(am[0]), .alloc_seq_o(aseq[0]),
        .alloc_last_o(alast[0]), .ovf_err_o(ovf[0]), .pipe_cycle_cnt_o(cnt[0])
    );

    memshare_alloc_sched #(.SEQ_CAP(2)) u_dut_cap2 (
        .sys_clk(sys_clk), .rstn(rstn), .in_valid_i(in_valid), .in_mask_i(in_mask),
        .in_ready_o(rdy[1]), .isGtr_o(gtr[1]), .is_drc_i(is_drc), .pipeCycle_begin_i(pipe),
        .alloc_valid_o(av[1]), .alloc_mask_o(am[1]), .alloc_seq_o(aseq[1]),
        .alloc_last_o(alast[1]), .ovf_err_o(ovf[1]), .pipe_cycle_cnt_o(cnt[1])
    );

    // One planned output cycle of a request: either a grant beat or a bubble.
    typedef struct packed {
        logic       v;
        logic       g;
        logic       s;
        logic       l;
        logic       f;
        logic       o;
        logic [7:0] m;
    } beat_t;

    beat_t      plan [2][0:3];
    int         plen [2];
    logic [7:0] fq   [2][0:7];
    int         fn   [2];
    logic       movf [2];
    logic [7:0] mcnt [2];

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int cap_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic load(input int k, input logic [7:0] req);
        int    idx[$];
        int    cap;
        beat_t b;
        logic [7:0] m1, m2;
        cap = cap_of(k);
        for (int i = 0; i < 8; i++) if (req[i]) idx.push_back(i);
        m1 = '0;
        m2 = '0;
        for (int j = 0; j < idx.size(); j++) begin
            if (j < cap) m1[idx[j]] = 1'b1;
            else if (j < 2 * cap) m2[idx[j]] = 1'b1;
        end
        b   = '0;
        b.v = 1'b1;
        b.g = (idx.size() > cap);
        b.l = !(idx.size() > cap);
        b.f = 1'b1;
        b.o = (idx.size() > 2 * cap);
        b.m = m1;
        plan[k][0] = b;
        plen[k] = 1;
        if (idx.size() > cap) begin
            b   = '0;
            b.v = 1'b1;
            b.s = 1'b1;
            b.l = 1'b1;
            b.m = m2;
            plan[k][1] = b;
            plen[k] = 2;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            plen[k] = 0;
            fn[k]   = 0;
            movf[k] = 1'b0;
            mcnt[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        logic  do_push;
        logic [7:0] req;
        mcnt[k] = mcnt[k] + 8'(pipe);
        do_push = in_valid && (fn[k] < 4);
        if (plen[k] > 0) begin
            if (plan[k][0].f) begin
                if (plan[k][0].o) movf[k] = 1'b1;
                if (is_drc[MEMSHARE_DRC2]) begin
                    plan[k][plen[k]] = '0;
                    plen[k]++;
                end
            end
            for (int i = 0; i < 3; i++) plan[k][i] = plan[k][i+1];
            plen[k]--;
        end
        if (plen[k] == 0 && fn[k] > 0) begin
            req = fq[k][0];
            for (int i = 0; i < 7; i++) fq[k][i] = fq[k][i+1];
            fn[k]--;
            load(k, req);
        end
        if (do_push) begin
            fq[k][fn[k]] = in_mask;
            fn[k]++;
        end
    endtask

    task automatic compare_all();
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            b = (plen[k] > 0) ? plan[k][0] : '0;
            expect_eq($sformatf("u%0d in_ready", k), 32'(rdy[k]), 32'(fn[k] < 4));
            expect_eq($sformatf("u%0d isGtr", k), 32'(gtr[k]), 32'(b.g));
            expect_eq($sformatf("u%0d alloc_valid", k), 32'(av[k]), 32'(b.v));
            expect_eq($sformatf("u%0d alloc_mask", k), 32'(am[k]), 32'(b.m));
            expect_eq($sformatf("u%0d alloc_seq", k), 32'(aseq[k]), 32'(b.s));
            expect_eq($sformatf("u%0d alloc_last", k), 32'(alast[k]), 32'(b.l));
            expect_eq($sformatf("u%0d ovf_err", k), 32'(ovf[k]), 32'(movf[k]));
            expect_eq($sformatf("u%0d pipe_cnt", k), 32'(cnt[k]), 32'(mcnt[k]));
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (rstn) begin
            model_step(0);
            model_step(1);
        end else begin
            model_reset();
        end
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_mask  = '0;
        is_drc   = '0;
        pipe     = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] m);
        in_valid = 1'b1;
        in_mask  = m;
        tick();
        in_valid = 1'b0;
    endtask

    logic [7:0] pick [5];
    int         pushed;
    int         guard;

    initial begin
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'hF3; pick[3] = 8'h01; pick[4] = 8'h80;
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge sys_clk);
        compare_all();
        rstn = 1'b1;
        tick();

        push_one(8'h07);
        repeat (4) tick();
        push_one(8'hF3);
        repeat (4) tick();

        pushed = 0;
        guard  = 0;
        while (pushed < 6 && guard < 40) begin
            in_valid = 1'b1;
            in_mask  = 8'hFF;
            if (fn[0] < 4) pushed++;
            tick();
            guard++;
        end
        expect_eq("six_pushes_accepted", 32'(pushed), 32'd6);
        in_valid = 1'b0;
        repeat (14) tick();

        push_one(8'h01);
        push_one(8'h01);
        is_drc[MEMSHARE_DRC2] = 1'b1;
        tick();
        is_drc = '0;
        repeat (5) tick();
        push_one(8'hFF);
        is_drc[MEMSHARE_DRC2] = 1'b1;
        tick();
        is_drc = '0;
        repeat (5) tick();

        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_mask  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
            is_drc   = MEMSHARE_DRC_NUM'($urandom);
            if ($urandom_range(0, 3) != 0) is_drc[MEMSHARE_DRC2] = 1'b0;
            pipe     = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_inputs();
        repeat (30) tick();

        for (int i = 0; i < 4; i++) push_one(8'hFF);
        guard = 0;
        while (!(plen[0] > 0 && plan[0][0].s) && guard < 20) begin
            tick();
            guard++;
        end
        expect_eq("reach_seq2", 32'(plen[0] > 0 && plan[0][0].s), 32'd1);
        #2 rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            expect_eq($sformatf("u%0d async_rst valid", k), 32'(av[k]), 32'd0);
            expect_eq($sformatf("u%0d async_rst mask", k), 32'(am[k]), 32'd0);
            expect_eq($sformatf("u%0d async_rst ovf", k), 32'(ovf[k]), 32'd0);
            expect_eq($sformatf("u%0d async_rst cnt", k), 32'(cnt[k]), 32'd0);
        end
        model_reset();
        @(negedge sys_clk);
        compare_all();
        rstn = 1'b1;
        tick();

        pipe = 1'b1;
        repeat (257) tick();
        pipe = 1'b0;
        tick();
        expect_eq("u0 cnt_after_257", 32'(cnt[0]), 32'd1);
        expect_eq("u1 cnt_after_257", 32'(cnt[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
